// File: rtl/video_pkg.sv
// Shared types and widths for the video memory read-slot arbiter.
package video_pkg;

   localparam int ADDR_W = 23;
   localparam int DATA_W = 64;
   localparam logic [1:0] DEF_VIDEO_SLOT = 2'd0;

   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_SHF,
      TAG_SND,
      TAG_VIK
   } owner_t;

endpackage

// File: rtl/video_read_pipe.sv
// Tracks the single outstanding video read: latency count, data capture
// and the one-cycle valid pulse to whoever owned the slot.
module video_read_pipe
   import video_pkg::*;
#(
   parameter int READ_LATENCY = 6
) (
   input  logic              clk_32,
   input  logic              reset,
   input  logic              start,
   input  owner_t            tag,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              shf_valid,
   output logic              snd_valid,
   output logic              vik_valid
);

   owner_t     owner;
   logic [3:0] cnt;
   logic       fire;

   always_ff @(posedge clk_32 or posedge reset) begin
      if (reset) begin
         owner     <= TAG_NONE;
         cnt       <= 4'd0;
         fire      <= 1'b0;
         rd_data   <= '0;
         shf_valid <= 1'b0;
         snd_valid <= 1'b0;
         vik_valid <= 1'b0;
      end else begin
         fire      <= 1'b0;
         shf_valid <= 1'b0;
         snd_valid <= 1'b0;
         vik_valid <= 1'b0;
         if (start) begin
            owner <= tag;
            cnt   <= 4'(READ_LATENCY);
         end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            // counter reaching zero is the edge mem_data is sampled
            if (cnt == 4'd1) begin
               rd_data <= mem_data;
               fire    <= 1'b1;
            end
         end
         if (fire) begin
            shf_valid <= (owner == TAG_SHF);
            snd_valid <= (owner == TAG_SND);
            vik_valid <= (owner == TAG_VIK);
         end
      end
   end

endmodule

// File: rtl/video_mem_arbiter.sv
// Grants the video read slot to shifter, DMA sound or Viking and keeps
// sound from starving behind the shifter.
module video_mem_arbiter
   import video_pkg::*;
#(
   parameter logic [1:0] VIDEO_SLOT   = DEF_VIDEO_SLOT,
   parameter int         READ_LATENCY = 6,
   parameter int         MAX_WAIT     = 3
) (
   input  logic              clk_32,
   input  logic              reset,
   input  logic              clk_8_en,
   input  logic [1:0]        bus_cycle,
   input  logic              viking_enable,
   input  logic              shf_req,
   input  logic [ADDR_W-1:0] shf_addr,
   output logic              shf_ack,
   output logic              shf_valid,
   input  logic              snd_req,
   input  logic [ADDR_W-1:0] snd_addr,
   output logic              snd_ack,
   output logic              snd_valid,
   input  logic              vik_req,
   input  logic [ADDR_W-1:0] vik_addr,
   output logic              vik_ack,
   output logic              vik_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              snd_starved
);

   owner_t            win;
   logic [ADDR_W-1:0] win_addr;
   logic [3:0]        wait_cnt;
   logic              slot;
   logic              grant;

   assign slot        = clk_8_en && (bus_cycle == VIDEO_SLOT);
   assign grant       = slot && (win != TAG_NONE);
   assign snd_starved = (wait_cnt == 4'(MAX_WAIT));

   always_comb begin
      win      = TAG_NONE;
      win_addr = '0;
      if (viking_enable) begin
         if (vik_req) win = TAG_VIK;
      end else if (snd_req && snd_starved) begin
         win = TAG_SND;
      end else if (shf_req) begin
         win = TAG_SHF;
      end else if (snd_req) begin
         win = TAG_SND;
      end
      case (win)
         TAG_SHF: win_addr = shf_addr;
         TAG_SND: win_addr = snd_addr;
         TAG_VIK: win_addr = vik_addr;
         default: win_addr = '0;
      endcase
   end

   always_ff @(posedge clk_32 or posedge reset) begin
      if (reset) begin
         mem_read <= 1'b0;
         mem_addr <= '0;
         shf_ack  <= 1'b0;
         snd_ack  <= 1'b0;
         vik_ack  <= 1'b0;
         wait_cnt <= 4'd0;
      end else begin
         mem_read <= grant;
         shf_ack  <= grant && (win == TAG_SHF);
         snd_ack  <= grant && (win == TAG_SND);
         vik_ack  <= grant && (win == TAG_VIK);
         if (grant) mem_addr <= win_addr;
         if (viking_enable) begin
            wait_cnt <= 4'd0;
         end else if (slot) begin
            if (!snd_req || win == TAG_SND)
               wait_cnt <= 4'd0;
            else if (!snd_starved)
               wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

   video_read_pipe #(
      .READ_LATENCY(READ_LATENCY)
   ) u_pipe (
      .clk_32   (clk_32),
      .reset    (reset),
      .start    (grant),
      .tag      (win),
      .mem_data (mem_data),
      .rd_data  (rd_data),
      .shf_valid(shf_valid),
      .snd_valid(snd_valid),
      .vik_valid(vik_valid)
   );

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Randomised and directed bench for video_mem_arbiter against a
// slot-level reference model.
module tb_video_mem_arbiter;

   localparam int LAT = 6;
   localparam int MW  = 3;

   logic        clk_32 = 1'b0;
   logic        reset;
   logic        clk_8_en;
   logic [1:0]  bus_cycle;
   logic        viking_enable;
   logic        shf_req, snd_req, vik_req;
   logic [22:0] shf_addr, snd_addr, vik_addr;
   logic        shf_ack, snd_ack, vik_ack;
   logic        shf_valid, snd_valid, vik_valid;
   logic [22:0] mem_addr;
   logic        mem_read;
   logic [63:0] mem_data;
   logic [63:0] rd_data;
   logic        snd_starved;

   int total = 0;
   int bad   = 0;

   video_mem_arbiter dut (
      .clk_32       (clk_32),
      .reset        (reset),
      .clk_8_en     (clk_8_en),
      .bus_cycle    (bus_cycle),
      .viking_enable(viking_enable),
      .shf_req      (shf_req),
      .shf_addr     (shf_addr),
      .shf_ack      (shf_ack),
      .shf_valid    (shf_valid),
      .snd_req      (snd_req),
      .snd_addr     (snd_addr),
      .snd_ack      (snd_ack),
      .snd_valid    (snd_valid),
      .vik_req      (vik_req),
      .vik_addr     (vik_addr),
      .vik_ack      (vik_ack),
      .vik_valid    (vik_valid),
      .mem_addr     (mem_addr),
      .mem_read     (mem_read),
      .mem_data     (mem_data),
      .rd_data      (rd_data),
      .snd_starved  (snd_starved)
   );

   always #5 clk_32 = ~clk_32;

   // bus phase generator: slot every 16 clk_32 cycles
   int k = 0;
   initial begin
      clk_8_en  = 1'b1;
      bus_cycle = 2'd0;
      forever begin
         @(posedge clk_32);
         #1;
         k++;
         clk_8_en  = (k % 4 == 0);
         bus_cycle = 2'((k / 4) % 4);
      end
   end

   task automatic chk(input string n, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   // reference model: slot-level view of grants and in-flight reads
   logic        m_shf_ack, m_snd_ack, m_vik_ack;
   logic        m_shf_valid, m_snd_valid, m_vik_valid;
   logic        m_mem_read;
   logic [22:0] m_mem_addr;
   logic [63:0] m_rd;
   int          m_wait;
   bit          inflight;
   int          owner;
   longint      cyc, cap_at, val_at;

   always @(posedge clk_32 or posedge reset) begin
      int  win;
      bit  is_slot;
      if (reset) begin
         {m_shf_ack, m_snd_ack, m_vik_ack} = '0;
         {m_shf_valid, m_snd_valid, m_vik_valid} = '0;
         m_mem_read = 1'b0;
         m_mem_addr = '0;
         m_rd       = '0;
         m_wait     = 0;
         inflight   = 0;
         cyc        = 0;
      end else begin
         cyc++;
         {m_shf_ack, m_snd_ack, m_vik_ack} = '0;
         {m_shf_valid, m_snd_valid, m_vik_valid} = '0;
         m_mem_read = 1'b0;
         if (inflight && cyc == cap_at) m_rd = mem_data;
         if (inflight && cyc == val_at) begin
            if (owner == 0) m_shf_valid = 1'b1;
            if (owner == 1) m_snd_valid = 1'b1;
            if (owner == 2) m_vik_valid = 1'b1;
            inflight = 0;
         end
         is_slot = clk_8_en && bus_cycle == 2'd0;
         win = -1;
         if (is_slot) begin
            if (viking_enable) begin
               if (vik_req) win = 2;
            end else if (snd_req && m_wait == MW) win = 1;
            else if (shf_req) win = 0;
            else if (snd_req) win = 1;
         end
         if (win >= 0) begin
            m_mem_read = 1'b1;
            m_mem_addr = (win == 0) ? shf_addr :
                         (win == 1) ? snd_addr : vik_addr;
            m_shf_ack  = (win == 0);
            m_snd_ack  = (win == 1);
            m_vik_ack  = (win == 2);
            inflight   = 1;
            owner      = win;
            cap_at     = cyc + LAT;
            val_at     = cyc + LAT + 1;
         end
         if (viking_enable) m_wait = 0;
         else if (is_slot) begin
            if (!snd_req || win == 1) m_wait = 0;
            else if (m_wait < MW) m_wait = m_wait + 1;
         end
      end
   end

   always @(negedge clk_32) begin
      chk("shf_ack", shf_ack, m_shf_ack);
      chk("snd_ack", snd_ack, m_snd_ack);
      chk("vik_ack", vik_ack, m_vik_ack);
      chk("valids", {shf_valid, snd_valid, vik_valid},
          {m_shf_valid, m_snd_valid, m_vik_valid});
      chk("mem_read", mem_read, m_mem_read);
      chk("mem_addr", mem_addr, m_mem_addr);
      chk("rd_data", rd_data, m_rd);
      chk("snd_starved", snd_starved, m_wait == MW);
   end

   task automatic tick();
      @(posedge clk_32);
      #1;
   endtask

   task automatic wait_slot();
      int n = 0;
      do begin
         @(posedge clk_32);
         n++;
      end while (!(clk_8_en && bus_cycle == 2'd0) && n < 64);
      #1;
      chk("slot_timeout", n < 64, 1);
   endtask

   initial begin
      logic flag;
      int   n;
      reset = 1'b1;
      viking_enable = 1'b0;
      {shf_req, snd_req, vik_req} = '0;
      shf_addr = '0; snd_addr = '0; vik_addr = '0;
      mem_data = '0;
      repeat (3) tick();
      chk("reset_outs", {mem_addr, mem_read, shf_ack, snd_ack, vik_ack,
          shf_valid, snd_valid, vik_valid, snd_starved}, 0);
      chk("reset_rd", rd_data, 0);
      reset = 1'b0;

      // shifter alone
      mem_data = 64'hDEAD_BEEF_0123_4567;
      shf_addr = 23'h01_2340;
      shf_req  = 1'b1;
      wait_slot();
      chk("a_ack", shf_ack, 1);
      chk("a_read", mem_read, 1);
      chk("a_addr", mem_addr, 23'h01_2340);
      shf_req = 1'b0;
      tick();
      chk("a_read_off", {mem_read, shf_ack}, 0);
      repeat (5) tick();
      chk("a_early", shf_valid, 0);
      tick();
      chk("a_valid", shf_valid, 1);
      chk("a_data", rd_data, 64'hDEAD_BEEF_0123_4567);
      tick();
      chk("a_valid_off", shf_valid, 0);
      chk("a_hold", rd_data, 64'hDEAD_BEEF_0123_4567);

      // contention: 3 shifter wins then sound
      snd_addr = 23'h22_0000;
      shf_req = 1'b1;
      snd_req = 1'b1;
      for (int s = 0; s < 8; s++) begin
         wait_slot();
         chk("b_snd", snd_ack, s % 4 == 3);
         chk("b_shf", shf_ack, s % 4 != 3);
         chk("b_starved", snd_starved, s % 4 == 2);
      end
      shf_req = 1'b0;
      snd_req = 1'b0;

      // Viking owns the path
      viking_enable = 1'b1;
      vik_addr = 23'h74_0000;
      {shf_req, snd_req, vik_req} = 3'b111;
      for (int s = 0; s < 8; s++) begin
         wait_slot();
         chk("c_vik", vik_ack, 1);
         chk("c_others", {shf_ack, snd_ack}, 0);
         chk("c_addr", mem_addr, 23'h74_0000);
      end
      {shf_req, snd_req, vik_req} = 3'b000;
      viking_enable = 1'b0;

      // mode switch with shifter read in flight
      shf_req = 1'b1;
      vik_req = 1'b1;
      wait_slot();
      chk("d_ack", shf_ack, 1);
      shf_req = 1'b0;
      repeat (2) tick();
      viking_enable = 1'b1;
      repeat (5) tick();
      chk("d_valid", shf_valid, 1);
      wait_slot();
      chk("d_vik", vik_ack, 1);
      vik_req = 1'b0;
      viking_enable = 1'b0;

      // reset with a read outstanding
      shf_addr = 23'h55_1234;
      shf_req = 1'b1;
      wait_slot();
      chk("e_ack", shf_ack, 1);
      shf_req = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      #1;
      chk("e_outs", {mem_addr, mem_read, shf_ack, snd_ack, vik_ack,
          shf_valid, snd_valid, vik_valid, snd_starved}, 0);
      chk("e_rd", rd_data, 0);
      tick();
      reset = 1'b0;
      flag = 1'b0;
      repeat (12) begin
         tick();
         if (shf_valid) flag = 1'b1;
      end
      chk("e_no_valid", flag, 0);
      shf_req = 1'b1;
      wait_slot();
      chk("e_reack", shf_ack, 1);
      shf_req = 1'b0;
      repeat (LAT + 1) tick();
      chk("e_revalid", shf_valid, 1);

      // request raised just after a slot
      wait_slot();
      tick();
      shf_req = 1'b1;
      flag = 1'b0;
      n = 0;
      repeat (14) begin
         tick();
         n++;
         if (mem_read || shf_ack) flag = 1'b1;
      end
      chk("f_quiet", flag, 0);
      tick();
      chk("f_ack", shf_ack, 1);
      shf_req = 1'b0;
      repeat (20) tick();

      // randomised traffic checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk_32);
         #1;
         mem_data = {$urandom, $urandom};
         if (shf_req && m_shf_ack) begin
            shf_req  = 1'($urandom_range(0, 1));
            shf_addr = 23'($urandom);
         end else if (!shf_req && $urandom_range(0, 5) == 0) begin
            shf_req  = 1'b1;
            shf_addr = 23'($urandom);
         end
         if (snd_req && m_snd_ack) begin
            snd_req  = 1'($urandom_range(0, 1));
            snd_addr = 23'($urandom);
         end else if (!snd_req && $urandom_range(0, 7) == 0) begin
            snd_req  = 1'b1;
            snd_addr = 23'($urandom);
         end
         if (vik_req && m_vik_ack) begin
            vik_req  = 1'($urandom_range(0, 1));
            vik_addr = 23'($urandom);
         end else if (!vik_req && $urandom_range(0, 7) == 0) begin
            vik_req  = 1'b1;
            vik_addr = 23'($urandom);
         end
         if ($urandom_range(0, 150) == 0) viking_enable = ~viking_enable;
      end

      repeat (20) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
